// File: rtl/panda_data_bus_arbiter.sv
// Round-robin arbiter sharing the data-memory port between the LSU (m0)
// and the debug/DMA port (m1); one outstanding transaction at a time.
//
// Ports:
//   clk_i, rst_ni           clock, async active-low reset
//   m0_* / m1_*             requester side: req/addr/we/wdata in,
//                           gnt/rvalid/rdata out
//   mem_*                   memory side: req/addr/we/wdata out,
//                           gnt/rvalid/rdata in
module panda_data_bus_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,

    input  logic            m0_req_i,
    input  logic [AW-1:0]   m0_addr_i,
    input  logic [DW/8-1:0] m0_we_i,
    input  logic [DW-1:0]   m0_wdata_i,
    output logic            m0_gnt_o,
    output logic            m0_rvalid_o,
    output logic [DW-1:0]   m0_rdata_o,

    input  logic            m1_req_i,
    input  logic [AW-1:0]   m1_addr_i,
    input  logic [DW/8-1:0] m1_we_i,
    input  logic [DW-1:0]   m1_wdata_i,
    output logic            m1_gnt_o,
    output logic            m1_rvalid_o,
    output logic [DW-1:0]   m1_rdata_o,

    output logic            mem_req_o,
    output logic [AW-1:0]   mem_addr_o,
    output logic [DW/8-1:0] mem_we_o,
    output logic [DW-1:0]   mem_wdata_o,
    input  logic            mem_gnt_i,
    input  logic            mem_rvalid_i,
    input  logic [DW-1:0]   mem_rdata_i
);

    typedef enum logic {
        IDLE,
        WAIT
    } state_t;

    state_t state_q, state_d;
    logic   owner_q, owner_d;
    logic   rr_last_q, rr_last_d;
    logic   lock_q, lock_d;
    logic   lock_sel_q, lock_sel_d;

    logic   can_issue;
    logic   sel;
    logic   sel_req;
    logic   issue;
    logic   hs;
    logic   resp;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            owner_q    <= 1'b0;
            rr_last_q  <= 1'b1;
            lock_q     <= 1'b0;
            lock_sel_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            rr_last_q  <= rr_last_d;
            lock_q     <= lock_d;
            lock_sel_q <= lock_sel_d;
        end
    end

    // Issue is allowed when idle or in the cycle the outstanding response
    // returns; reset gates it so the port goes quiet immediately.
    always_comb begin
        can_issue = rst_ni && ((state_q == IDLE) || mem_rvalid_i);
        sel       = 1'b0;
        sel_req   = 1'b0;
        if (lock_q) begin
            // A stalled request keeps its selection until granted.
            sel     = lock_sel_q;
            sel_req = lock_sel_q ? m1_req_i : m0_req_i;
        end else begin
            unique case ({m1_req_i, m0_req_i})
                2'b11: begin
                    sel     = ~rr_last_q;
                    sel_req = 1'b1;
                end
                2'b10: begin
                    sel     = 1'b1;
                    sel_req = 1'b1;
                end
                2'b01: begin
                    sel     = 1'b0;
                    sel_req = 1'b1;
                end
                default: begin
                    sel     = 1'b0;
                    sel_req = 1'b0;
                end
            endcase
        end
        issue = can_issue & sel_req;
        hs    = issue & mem_gnt_i;
        resp  = (state_q == WAIT) & mem_rvalid_i;
    end

    always_comb begin
        mem_req_o   = issue;
        mem_addr_o  = '0;
        mem_we_o    = '0;
        mem_wdata_o = '0;
        if (issue) begin
            mem_addr_o  = sel ? m1_addr_i  : m0_addr_i;
            mem_we_o    = sel ? m1_we_i    : m0_we_i;
            mem_wdata_o = sel ? m1_wdata_i : m0_wdata_i;
        end
        m0_gnt_o    = hs & ~sel;
        m1_gnt_o    = hs & sel;
        m0_rvalid_o = resp & ~owner_q;
        m1_rvalid_o = resp & owner_q;
        m0_rdata_o  = m0_rvalid_o ? mem_rdata_i : '0;
        m1_rdata_o  = m1_rvalid_o ? mem_rdata_i : '0;
    end

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        rr_last_d  = rr_last_q;
        lock_d     = 1'b0;
        lock_sel_d = lock_sel_q;
        if (resp) begin
            state_d = IDLE;
        end
        if (hs) begin
            state_d   = WAIT;
            owner_d   = sel;
            rr_last_d = sel;
        end else if (issue) begin
            lock_d     = 1'b1;
            lock_sel_d = sel;
        end
    end

endmodule

// File: tb/tb_panda_data_bus_arbiter.sv
// Scoreboard bench for panda_data_bus_arbiter: stimulus pushes expected
// grants/responses, a negedge monitor pops and compares them.
module tb_panda_data_bus_arbiter;

    typedef struct packed {
        logic [1:0]  gnt;
        logic [31:0] addr;
        logic [3:0]  we;
        logic [31:0] wdata;
    } gnt_t;

    typedef struct packed {
        logic [1:0]  rv;
        logic [31:0] data;
    } rsp_t;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        m0_req_i = 1'b0;
    logic [31:0] m0_addr_i = '0;
    logic [3:0]  m0_we_i = '0;
    logic [31:0] m0_wdata_i = '0;
    logic        m0_gnt_o, m0_rvalid_o;
    logic [31:0] m0_rdata_o;
    logic        m1_req_i = 1'b0;
    logic [31:0] m1_addr_i = '0;
    logic [3:0]  m1_we_i = '0;
    logic [31:0] m1_wdata_i = '0;
    logic        m1_gnt_o, m1_rvalid_o;
    logic [31:0] m1_rdata_o;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic [3:0]  mem_we_o;
    logic [31:0] mem_wdata_o;
    logic        mem_gnt_i = 1'b0;
    logic        mem_rvalid_i = 1'b0;
    logic [31:0] mem_rdata_i = '0;

    int errors = 0;
    int checks = 0;
    gnt_t gq[$];
    rsp_t rq[$];

    always #5 clk_i = ~clk_i;

    panda_data_bus_arbiter #(.AW(32), .DW(32)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .m0_req_i(m0_req_i), .m0_addr_i(m0_addr_i),
        .m0_we_i(m0_we_i), .m0_wdata_i(m0_wdata_i),
        .m0_gnt_o(m0_gnt_o), .m0_rvalid_o(m0_rvalid_o),
        .m0_rdata_o(m0_rdata_o),
        .m1_req_i(m1_req_i), .m1_addr_i(m1_addr_i),
        .m1_we_i(m1_we_i), .m1_wdata_i(m1_wdata_i),
        .m1_gnt_o(m1_gnt_o), .m1_rvalid_o(m1_rvalid_o),
        .m1_rdata_o(m1_rdata_o),
        .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
        .mem_we_o(mem_we_o), .mem_wdata_o(mem_wdata_o),
        .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
        .mem_rdata_i(mem_rdata_i)
    );

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk_i) begin
        if (m0_gnt_o || m1_gnt_o) begin
            if (gq.size() == 0) begin
                chk("gnt_unexpected", {m1_gnt_o, m0_gnt_o}, 2'b00);
            end else begin
                gnt_t e;
                e = gq.pop_front();
                chk("gnt_who", {m1_gnt_o, m0_gnt_o}, e.gnt);
                chk("gnt_addr", mem_addr_o, e.addr);
                chk("gnt_we", mem_we_o, e.we);
                chk("gnt_wdata", mem_wdata_o, e.wdata);
            end
        end
        if (m0_rvalid_o || m1_rvalid_o) begin
            if (rq.size() == 0) begin
                chk("rv_unexpected", {m1_rvalid_o, m0_rvalid_o}, 2'b00);
            end else begin
                rsp_t r;
                r = rq.pop_front();
                chk("rv_who", {m1_rvalid_o, m0_rvalid_o}, r.rv);
                chk("rv_data", {m1_rdata_o, m0_rdata_o},
                    r.rv[1] ? {r.data, 32'h0} : {32'h0, r.data});
            end
        end
    end

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        m0_req_i = 0; m1_req_i = 0;
        m0_we_i = '0; m1_we_i = '0;
        m0_wdata_i = '0; m1_wdata_i = '0;
        mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_ni = 0;
        cyc();
        cyc();
        rst_ni = 1;
        cyc();
    endtask

    task automatic push_g(input logic [1:0] g, input logic [31:0] a,
                          input logic [3:0] w, input logic [31:0] d);
        gnt_t e;
        e.gnt = g; e.addr = a; e.we = w; e.wdata = d;
        gq.push_back(e);
    endtask

    task automatic push_r(input logic [1:0] v, input logic [31:0] d);
        rsp_t r;
        r.rv = v; r.data = d;
        rq.push_back(r);
    endtask

    task automatic quiet_chk(input string name);
        @(negedge clk_i);
        chk(name, {m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o,
                   mem_req_o, m0_rdata_o, m1_rdata_o}, '0);
    endtask

    initial begin
        // reset state
        idle_inputs();
        #2;
        chk("reset_outs", {m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o,
                           mem_req_o, mem_addr_o, m0_rdata_o}, '0);
        cyc();
        rst_ni = 1;
        cyc();

        // single m0 read
        m0_req_i = 1; m0_addr_i = 32'h100; mem_gnt_i = 1;
        push_g(2'b01, 32'h100, 4'h0, 32'h0);
        cyc();
        m0_req_i = 0; mem_gnt_i = 0;
        mem_rvalid_i = 1; mem_rdata_i = 32'hDEADBEEF;
        push_r(2'b01, 32'hDEADBEEF);
        cyc();
        idle_inputs();
        cyc();

        // contention: alternating grants, no bubbles
        do_reset();
        m0_req_i = 1; m0_addr_i = 32'h10;
        m1_req_i = 1; m1_addr_i = 32'h20;
        mem_gnt_i = 1;
        for (int i = 0; i < 5; i++) begin
            if (i < 4) begin
                push_g((i % 2 == 0) ? 2'b01 : 2'b10,
                       (i % 2 == 0) ? 32'h10 : 32'h20, 4'h0, 32'h0);
            end
            if (i > 0) begin
                mem_rvalid_i = 1;
                mem_rdata_i = 32'h1000 + i;
                push_r((i % 2 == 1) ? 2'b01 : 2'b10, 32'h1000 + i);
            end
            if (i == 4) begin
                m0_req_i = 0; m1_req_i = 0; mem_gnt_i = 0;
            end
            @(negedge clk_i);
            if (i < 4) chk("contention_req", mem_req_o, 1'b1);
            cyc();
        end
        idle_inputs();
        cyc();

        // stall: selection held while memory withholds gnt
        do_reset();
        m1_req_i = 1; m1_addr_i = 32'h300;
        for (int i = 0; i < 3; i++) begin
            if (i == 1) begin
                m0_req_i = 1; m0_addr_i = 32'h104;
            end
            @(negedge clk_i);
            chk("stall_addr", {mem_req_o, mem_addr_o}, {1'b1, 32'h300});
            cyc();
        end
        mem_gnt_i = 1;
        push_g(2'b10, 32'h300, 4'h0, 32'h0);
        cyc();
        m1_req_i = 0;
        mem_rvalid_i = 1; mem_rdata_i = 32'hA1;
        push_r(2'b10, 32'hA1);
        push_g(2'b01, 32'h104, 4'h0, 32'h0);
        cyc();
        m0_req_i = 0; mem_gnt_i = 0;
        mem_rdata_i = 32'hA2;
        push_r(2'b01, 32'hA2);
        cyc();
        idle_inputs();
        cyc();

        // m1 byte write
        do_reset();
        m1_req_i = 1; m1_addr_i = 32'h202;
        m1_we_i = 4'b0100; m1_wdata_i = 32'h00AB0000;
        mem_gnt_i = 1;
        push_g(2'b10, 32'h202, 4'b0100, 32'h00AB0000);
        cyc();
        m1_req_i = 0; mem_gnt_i = 0;
        mem_rvalid_i = 1; mem_rdata_i = 32'h55;
        push_r(2'b10, 32'h55);
        cyc();
        idle_inputs();
        cyc();

        // spurious rvalid in IDLE, then a normal read
        mem_rvalid_i = 1; mem_rdata_i = 32'hBAD;
        quiet_chk("spurious_rv");
        cyc();
        idle_inputs();
        m0_req_i = 1; m0_addr_i = 32'h180; mem_gnt_i = 1;
        push_g(2'b01, 32'h180, 4'h0, 32'h0);
        cyc();
        m0_req_i = 0; mem_gnt_i = 0;
        mem_rvalid_i = 1; mem_rdata_i = 32'hC0FFEE;
        push_r(2'b01, 32'hC0FFEE);
        cyc();
        idle_inputs();
        cyc();

        // reset while a transaction is outstanding
        m0_req_i = 1; m0_addr_i = 32'h140; mem_gnt_i = 1;
        push_g(2'b01, 32'h140, 4'h0, 32'h0);
        cyc();
        rst_ni = 0;
        #1;
        chk("rst_mid_outs", {m0_gnt_o, m1_gnt_o, m0_rvalid_o,
                             m1_rvalid_o, mem_req_o}, '0);
        cyc();
        idle_inputs();
        rst_ni = 1;
        mem_rvalid_i = 1; mem_rdata_i = 32'h77;
        quiet_chk("rst_late_rv");
        cyc();
        idle_inputs();
        cyc();
        cyc();

        chk("gnt_queue_empty", gq.size(), 0);
        chk("rsp_queue_empty", rq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
